// File: rtl/zqe_pkg.sv
// rtl/zqe_pkg.sv - shared states, block length and zigzag table (ZIGZAG_REORDER_EN)
package zqe_pkg;

   localparam int BLOCK_LEN = 64;
   localparam int COEF_W    = 16;

   typedef enum logic [3:0] {
      ST_IDLE         = 4'd0,
      ST_LOAD_DATA    = 4'd1,
      ST_PROCESS_DATA = 4'd2,
      ST_SAVE_DATA    = 4'd3,
      ST_DONE         = 4'd4
   } zqe_state_e;

   // Result index k -> raster position of the standard JPEG zigzag scan
   localparam logic [5:0] ZZ [BLOCK_LEN] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   function automatic logic [5:0] src_index(input logic [5:0] k);
`ifdef ZIGZAG_REORDER_EN
      return ZZ[k];
`else
      return k;
`endif
   endfunction

endpackage

// File: rtl/zigzag_quant_engine_coef_quantizer.sv
// rtl/zigzag_quant_engine_coef_quantizer.sv - registered sign-magnitude round-half-away quantizer
module coef_quantizer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [15:0]           in_coef,
   input  logic [3:0]            in_qshift,
   input  logic [5:0]            in_idx,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [5:0]            out_idx
);

   logic                  neg;
   logic [17:0]           mag;
   logic [17:0]           bias;
   logic [17:0]           shifted;
   logic [17:0]           rounded;
   logic [DATA_WIDTH-1:0] q_word;

   // qshift=0 needs no bias; magnitude and sign round-trip back to the input value
   always_comb begin
      neg     = in_coef[15];
      mag     = neg ? (18'd0 - {{2{in_coef[15]}}, in_coef}) : {2'b00, in_coef};
      bias    = (in_qshift == 4'd0) ? 18'd0 : (18'd1 << (in_qshift - 4'd1));
      shifted = (mag + bias) >> in_qshift;
      rounded = neg ? (18'd0 - shifted) : shifted;
      q_word  = {{(DATA_WIDTH-18){rounded[17]}}, rounded};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
      end else begin
         out_valid <= in_valid;
         out_data  <= q_word;
         out_idx   <= in_idx;
      end
   end

endmodule

// File: rtl/zigzag_quant_engine.sv
// rtl/zigzag_quant_engine.sv - block load, quantize and result store engine (ZIGZAG_REORDER_EN)
module zigzag_quant_engine #(
   parameter int DATA_WIDTH = 32,
   parameter int BLOCK_LEN  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [3:0]            qshift,
   output logic [7:0]            data_in_addr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [7:0]            data_out_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [3:0]            state_out
);

   import zqe_pkg::*;

   localparam logic [5:0] LAST = 6'(BLOCK_LEN - 1);

   zqe_state_e state, state_nxt;

   logic [5:0]            load_cnt;
   logic [5:0]            proc_cnt;
   logic [5:0]            save_cnt;
   logic [3:0]            qshift_q;
   logic [15:0]           coef_buf [BLOCK_LEN];
   logic [DATA_WIDTH-1:0] result   [BLOCK_LEN];

   logic                  q_valid;
   logic [DATA_WIDTH-1:0] q_data;
   logic [5:0]            q_idx;

   logic                  unused_bits;
   assign unused_bits = ^{data_in[DATA_WIDTH-1:16], data_out_addr[7:6]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:         if (start)            state_nxt = ST_LOAD_DATA;
         ST_LOAD_DATA:    if (load_cnt == LAST) state_nxt = ST_PROCESS_DATA;
         ST_PROCESS_DATA: if (proc_cnt == LAST) state_nxt = ST_SAVE_DATA;
         ST_SAVE_DATA:    if (save_cnt == LAST) state_nxt = ST_DONE;
         ST_DONE:         if (!start)           state_nxt = ST_IDLE;
         default:                               state_nxt = ST_IDLE;
      endcase
   end

   // Counters wrap to zero on their last step, so each run starts clean
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt <= '0;
         proc_cnt <= '0;
         save_cnt <= '0;
         qshift_q <= '0;
      end else begin
         case (state)
            ST_IDLE:         if (start) qshift_q <= qshift;
            ST_LOAD_DATA:    load_cnt <= load_cnt + 6'd1;
            ST_PROCESS_DATA: proc_cnt <= proc_cnt + 6'd1;
            ST_SAVE_DATA:    save_cnt <= save_cnt + 6'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_LOAD_DATA) coef_buf[load_cnt] <= data_in[15:0];
   end

   coef_quantizer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_quant (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (state == ST_PROCESS_DATA),
      .in_coef   (coef_buf[src_index(proc_cnt)]),
      .in_qshift (qshift_q),
      .in_idx    (proc_cnt),
      .out_valid (q_valid),
      .out_data  (q_data),
      .out_idx   (q_idx)
   );

   // The last quantized word lands during the first SAVE_DATA cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BLOCK_LEN; i++) result[i] <= '0;
      end else if (q_valid) begin
         result[q_idx] <= q_data;
      end
   end

   assign data_in_addr = (state == ST_LOAD_DATA) ? {2'b00, load_cnt} : 8'd0;
   assign data_out     = result[data_out_addr[5:0]];
   assign state_out    = state;

endmodule

// File: tb/tb_zigzag_quant_engine.sv
// tb/tb_zigzag_quant_engine.sv - randomized self-checking bench for zigzag_quant_engine
module tb_zigzag_quant_engine;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [3:0]  qshift;
   logic [7:0]  data_in_addr;
   logic [31:0] data_in;
   logic [7:0]  data_out_addr;
   logic [31:0] data_out;
   logic [3:0]  state_out;

   logic [31:0] mem [64];
   int total = 0;
   int bad   = 0;

   zigzag_quant_engine #(
      .DATA_WIDTH (32),
      .BLOCK_LEN  (64)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .qshift        (qshift),
      .data_in_addr  (data_in_addr),
      .data_in       (data_in),
      .data_out_addr (data_out_addr),
      .data_out      (data_out),
      .state_out     (state_out)
   );

   assign data_in = mem[data_in_addr[5:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Raster position stored at result index k, derived by walking the anti-diagonals
   function automatic int raster_of(int k);
`ifdef ZIGZAG_REORDER_EN
      int n = 0;
      for (int s = 0; s < 15; s++) begin
         for (int j = 0; j < 8; j++) begin
            int row = (s % 2 == 0) ? (((s < 8) ? s : 7) - j) : (((s < 8) ? 0 : s - 7) + j);
            int col = s - row;
            if (row >= 0 && row < 8 && col >= 0 && col < 8) begin
               if (n == k) return row * 8 + col;
               n++;
            end
         end
      end
      return -1;
`else
      return k;
`endif
   endfunction

   // Round half away from zero of c / 2^q, via integer division of doubled magnitude
   function automatic logic [31:0] quant(input logic [15:0] raw, input int q);
      int c, d, mag, r;
      c = int'($signed(raw));
      if (q == 0) return 32'(c);
      d   = 1 << q;
      mag = (c < 0) ? -c : c;
      r   = (2 * mag + d) / (2 * d);
      return 32'((c < 0) ? -r : r);
   endfunction

   task automatic check_results(input string tag, input logic [31:0] exp_r [64]);
      for (int k = 0; k < 64; k++) begin
         data_out_addr = {2'($urandom), 6'(k)};
         #1;
         check($sformatf("%s res[%0d]", tag, k), data_out, exp_r[k]);
      end
   endtask

   task automatic run_block(input string tag, input logic [3:0] qs, input int drop_at, input int save_qs);
      logic [31:0] exp_r [64];
      int n1, n2, n3, cyc;
      for (int k = 0; k < 64; k++) exp_r[k] = quant(mem[raster_of(k)][15:0], int'(qs));
      n1 = 0; n2 = 0; n3 = 0; cyc = 0;
      qshift = qs;
      start  = 1'b1;
      @(negedge clk);
      while (state_out != 4'd4 && cyc < 400) begin
         case (state_out)
            4'd1: begin
               check($sformatf("%s in_addr", tag), 32'(data_in_addr), 32'(n1));
               n1++;
               if (drop_at >= 0 && n1 == drop_at) start = 1'b0;
            end
            4'd2: n2++;
            4'd3: begin
               n3++;
               if (save_qs >= 0) qshift = 4'(save_qs);
            end
            default: ;
         endcase
         cyc++;
         @(negedge clk);
      end
      check($sformatf("%s reach done", tag), 32'(state_out), 32'd4);
      check($sformatf("%s load len", tag), 32'(n1), 32'd64);
      check($sformatf("%s proc len", tag), 32'(n2), 32'd64);
      check($sformatf("%s save len", tag), 32'(n3), 32'd64);
      if (start) begin
         @(negedge clk);
         check($sformatf("%s done hold", tag), 32'(state_out), 32'd4);
         start = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s idle", tag), 32'(state_out), 32'd0);
      check($sformatf("%s idle addr", tag), 32'(data_in_addr), 32'd0);
      check_results(tag, exp_r);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      qshift = 4'd0;
      data_out_addr = 8'd0;
      for (int i = 0; i < 64; i++) mem[i] = 32'(i);
      #1;
      check("reset state", 32'(state_out), 32'd0);
      check("reset in_addr", 32'(data_in_addr), 32'd0);
      check("reset data_out", data_out, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle without start", 32'(state_out), 32'd0);

      run_block("ramp", 4'd0, -1, -1);
`ifdef ZIGZAG_REORDER_EN
      data_out_addr = 8'd2;
      #1;
      check("ramp zz[2]", data_out, 32'd8);
`endif

      fill_random();
      mem[0] = 32'h0000_FFF3;
      mem[1] = 32'd13;
      mem[2] = 32'd12;
      run_block("q3", 4'd3, -1, -1);

      fill_random();
      mem[0] = 32'h0000_8000;
      mem[3] = 32'd1;
      mem[4] = 32'd0;
      run_block("q15", 4'd15, -1, -1);
      run_block("q0", 4'd0, -1, -1);
      run_block("q1", 4'd1, -1, -1);

      fill_random();
      run_block("drop", 4'($urandom_range(0, 15)), 10, -1);

      fill_random();
      qshift = 4'd4;
      start  = 1'b1;
      begin
         int cyc = 0;
         while (state_out != 4'd2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
         end
         check("mid reach proc", 32'(state_out), 32'd2);
      end
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst state", 32'(state_out), 32'd0);
      check("mid rst in_addr", 32'(data_in_addr), 32'd0);
      start = 1'b0;
      for (int k = 0; k < 64; k += 9) begin
         data_out_addr = 8'(k);
         #1;
         check($sformatf("mid rst res[%0d]", k), data_out, 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post rst idle", 32'(state_out), 32'd0);
      run_block("after rst", 4'd4, -1, -1);

      fill_random();
      run_block("qs 2->5", 4'd2, -1, 5);
      fill_random();
      run_block("qs next 5", 4'd5, -1, -1);

      for (int r = 0; r < 3; r++) begin
         fill_random();
         run_block($sformatf("rand%0d", r), 4'($urandom_range(0, 15)), -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/zigzag_quant_engine.md
ZIGZAG_QUANT_ENGINE -- requirements
Module: zigzag_quant_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of the input and output data words.
REQ-002 SHALL have parameter BLOCK_LEN, default 64, the number of coefficients per block (one 8x8 block).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: level request to process one block.
REQ-006 SHALL have port qshift, input, 4 bits: quantization shift, sampled when a run begins.
REQ-007 SHALL have port data_in_addr, output, 8 bits: read address into the host write area.
REQ-008 SHALL have port data_in, input, DATA_WIDTH: combinational read data for data_in_addr.
REQ-009 SHALL have port data_out_addr, input, 8 bits: host-driven result index.
REQ-010 SHALL have port data_out, output, DATA_WIDTH: combinational result word for data_out_addr.
REQ-011 SHALL have port state_out, output, 4 bits: current state code.

Function
REQ-012 SHALL use states IDLE=0, LOAD_DATA=1, PROCESS_DATA=2, SAVE_DATA=3, DONE=4, presented directly on state_out.
REQ-013 In IDLE with start=1, SHALL latch qshift and enter LOAD_DATA on the next edge; otherwise it SHALL stay in IDLE.
REQ-014 In LOAD_DATA, data_in_addr SHALL step 0..63, one per cycle; data_in[15:0] SHALL be captured as a signed coefficient into buffer entry addr; the state SHALL exit to PROCESS_DATA after entry 63 (exactly 64 cycles).
REQ-015 In PROCESS_DATA, SHALL quantize one entry per cycle over 64 cycles, then enter SAVE_DATA.
REQ-016 Quantization SHALL be sign-magnitude: |c| plus 2^(qshift-1), computed in 18 bits, shifted right by qshift (round half away from zero), sign restored, sign-extended to DATA_WIDTH; qshift=0 SHALL pass c unchanged.
REQ-017 Boundaries: c=-32768 with qshift=0 SHALL give 0xFFFF8000; c=-32768 with qshift=15 SHALL give 0xFFFFFFFF; c=+1 with qshift=1 SHALL give 1; c=0 SHALL always give 0.
REQ-018 SAVE_DATA SHALL last exactly 64 cycles, then DONE; data_out SHALL equal result[data_out_addr[5:0]] in all states.
REQ-019 DONE SHALL hold while start=1 and return to IDLE when start=0, so that no run retriggers on a held level.
REQ-020 start deasserting during LOAD_DATA, PROCESS_DATA or SAVE_DATA SHALL be ignored; the run SHALL complete.
REQ-021 data_in_addr SHALL be 0 outside LOAD_DATA.
REQ-022 The qshift latched at run start SHALL be used for the whole run; mid-run qshift changes SHALL have no effect.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, state_out=0, data_in_addr=0, load/process/save counters=0, latched qshift=0, and all result entries=0 (data_out=0); this SHALL hold for reset mid-run as well.
REQ-024 After reset, the first run SHALL require start=1 sampled in IDLE.

Configuration
REQ-025 With macro ZIGZAG_REORDER_EN defined, result index k SHALL hold the quantized coefficient of raster position ZZ[k] (standard JPEG zigzag; ZZ[0..5]=0,1,8,16,9,2; ZZ[63]=63).
REQ-026 Without ZIGZAG_REORDER_EN, result index k SHALL hold raster position k.

Structure
REQ-027 A shared package zqe_pkg SHALL hold the state enum, BLOCK_LEN, and the 64-entry ZZ constant table.
REQ-028 Sub-module coef_quantizer SHALL implement REQ-016 as a one-cycle registered unit.

Verification
REQ-029 Ramp input mem[i]=i, qshift=0, start held high: state_out SHALL sequence 1 (64 cycles), 2 (64 cycles), 3 (64 cycles), then 4; without the macro data_out[k]=k; with the macro data_out[2]=8.
REQ-030 mem[0]=0x0000_FFF3 (-13), mem[1]=13, mem[2]=12, qshift=3: results SHALL be 0xFFFFFFFE, 2, 2 (raster order).
REQ-031 mem[0]=0x8000, qshift=15: data_out[0]=0xFFFFFFFF; with qshift=0: data_out[0]=0xFFFF8000.
REQ-032 Drop start at cycle 10 of LOAD_DATA: the run SHALL complete to DONE, then IDLE one cycle after DONE is observed with start=0.
REQ-033 Assert rst_n=0 mid-PROCESS_DATA: state_out=0 and data_out=0 immediately, without a clock edge; a new start SHALL then yield correct results.
REQ-034 Change qshift from 2 to 5 during SAVE_DATA: results SHALL reflect qshift=2; the next run SHALL use 5.
